// File: rtl/hls_macc_seq_pkg.sv
// Shared types and indices for the hls_macc sequencer/collector.
// Optional watchdog: HLS_MACC_SEQ_TIMEOUT_EN (see hls_macc_seq.sv).
package hls_macc_seq_pkg;

    localparam int W = 32;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2,
        EMIT = 2'd3
    } state_t;

    localparam logic [1:0] RES_RET = 2'd0;
    localparam logic [1:0] RES_O13 = 2'd1;
    localparam logic [1:0] RES_O31 = 2'd2;
    localparam logic [1:0] RES_O30 = 2'd3;

    localparam int OP_IN1  = 0;
    localparam int OP_IN2  = 1;
    localparam int OP_IN3  = 2;
    localparam int OP_IN4  = 3;
    localparam int OP_IN7  = 4;
    localparam int OP_IN8  = 5;
    localparam int OP_IN9  = 6;
    localparam int OP_IN10 = 7;
    localparam int OP_IN14 = 8;
    localparam int OP_IN12 = 9;
    localparam int OP_IN15 = 10;
    localparam int OP_IN17 = 11;
    localparam int OP_IN19 = 12;
    localparam int OP_IN20 = 13;
    localparam int OP_IN22 = 14;
    localparam int OP_IN24 = 15;
    localparam int OP_IN27 = 16;
    localparam int OP_IN28 = 17;
    localparam int OP_IN29 = 18;
    localparam int OP_IN32 = 19;

endpackage

// File: rtl/hls_macc_seq_bank.sv
// Operand register file for one hls_macc frame, filled in order by a
// wrapping write index; contents are deliberately not reset.
module hls_macc_seq_bank #(
    parameter int N_OPS = 20,
    parameter int W     = 32
) (
    input  logic               ap_clk,
    input  logic               ap_rst,
    input  logic               wr_en,
    input  logic [W-1:0]       wr_data,
    output logic               wr_last,
    output logic [N_OPS*W-1:0] ops
);
    import hls_macc_seq_pkg::*;

    localparam int IW = $clog2(N_OPS);

    logic [IW-1:0] idx;
    logic [W-1:0]  mem [N_OPS];

    assign wr_last = wr_en && (idx == IW'(N_OPS - 1));

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            idx <= '0;
        end else if (wr_en) begin
            idx <= wr_last ? '0 : idx + IW'(1);
        end
    end

    always_ff @(posedge ap_clk) begin
        if (wr_en) begin
            mem[idx] <= wr_data;
        end
    end

    for (genvar k = 0; k < N_OPS; k++) begin : g_flat
        assign ops[k*W +: W] = mem[k];
    end

endmodule

// File: rtl/hls_macc_seq.sv
// Sequencer/collector around the hls_macc core (ap_ctrl_hs).
// Define HLS_MACC_SEQ_TIMEOUT_EN to enable the WAIT-state watchdog.
module hls_macc_seq #(
    parameter int          N_OPS       = 20,
    parameter int          W           = 32,
    parameter logic [31:0] OUT30_INIT  = 32'd0,
    parameter int          TIMEOUT_CYC = 64
) (
    input  logic               ap_clk,
    input  logic               ap_rst,
    input  logic [W-1:0]       s_data,
    input  logic               s_valid,
    output logic               s_ready,
    output logic [N_OPS*W-1:0] core_ops,
    output logic               core_start,
    input  logic               core_done,
    input  logic [W-1:0]       core_out13,
    input  logic               core_out13_vld,
    input  logic [W-1:0]       core_out30_o,
    input  logic               core_out30_vld,
    output logic [W-1:0]       core_out30_i,
    input  logic [W-1:0]       core_out31,
    input  logic               core_out31_vld,
    input  logic [W-1:0]       core_return,
    output logic [W-1:0]       m_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               m_last,
    output logic               m_err,
    output logic               busy
);
    import hls_macc_seq_pkg::*;

    state_t       state;
    logic [1:0]   out_idx;
    logic [1:0]   nidx;
    logic [W-1:0] nword;
    logic [W-1:0] out30_q;
    logic [W-1:0] r_ret;
    logic [W-1:0] r13;
    logic [W-1:0] r31;
    logic [W-1:0] r30;
    logic         written30;
    logic         s_hs;
    logic         m_hs;
    logic         frame_done;
    logic         tmo_hit;

    assign s_hs         = s_valid && s_ready && !ap_rst;
    assign m_hs         = m_valid && m_ready;
    assign core_out30_i = out30_q;

    hls_macc_seq_bank #(
        .N_OPS(N_OPS),
        .W    (W)
    ) u_bank (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .wr_en  (s_hs),
        .wr_data(s_data),
        .wr_last(frame_done),
        .ops    (core_ops)
    );

    always_comb begin
        nidx  = out_idx + 2'd1;
        nword = r30;
        unique case (nidx)
            RES_RET: nword = r_ret;
            RES_O13: nword = r13;
            RES_O31: nword = r31;
            default: nword = r30;
        endcase
    end

`ifdef HLS_MACC_SEQ_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TMO_W-1:0] tmo_cnt;

    assign tmo_hit = (state == WAIT) && !core_done &&
                     (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

    // m_err marks the whole record and drops once word 3 is taken.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            tmo_cnt <= '0;
            m_err   <= 1'b0;
        end else begin
            tmo_cnt <= (state == WAIT) ? tmo_cnt + TMO_W'(1) : '0;
            if (tmo_hit) begin
                m_err <= 1'b1;
            end else if (state == EMIT && m_hs && out_idx == RES_O30) begin
                m_err <= 1'b0;
            end
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign m_err   = 1'b0;
`endif

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state      <= LOAD;
            out_idx    <= 2'd0;
            s_ready    <= 1'b1;
            core_start <= 1'b0;
            m_valid    <= 1'b0;
            m_last     <= 1'b0;
            m_data     <= '0;
            busy       <= 1'b0;
            out30_q    <= OUT30_INIT[W-1:0];
            r_ret      <= '0;
            r13        <= '0;
            r31        <= '0;
            r30        <= '0;
            written30  <= 1'b0;
        end else begin
            unique case (state)
                LOAD: begin
                    if (frame_done) begin
                        state      <= RUN;
                        s_ready    <= 1'b0;
                        core_start <= 1'b1;
                        busy       <= 1'b1;
                        written30  <= 1'b0;
                    end
                end
                RUN: begin
                    core_start <= 1'b0;
                    if (core_out13_vld) begin
                        r13 <= core_out13;
                    end
                    state <= WAIT;
                end
                WAIT: begin
                    if (core_out30_vld) begin
                        out30_q   <= core_out30_o;
                        r30       <= core_out30_o;
                        written30 <= 1'b1;
                    end
                    if (core_done) begin
                        r_ret <= core_return;
                        if (core_out31_vld) begin
                            r31 <= core_out31;
                        end
                        // One-state path: report the untouched out30 value.
                        if (!written30 && !core_out30_vld) begin
                            r30 <= out30_q;
                        end
                        m_data  <= core_return;
                        m_valid <= 1'b1;
                        m_last  <= 1'b0;
                        out_idx <= RES_RET;
                        state   <= EMIT;
                    end else if (tmo_hit) begin
                        r_ret   <= '0;
                        r13     <= '0;
                        r31     <= '0;
                        r30     <= core_out30_vld ? core_out30_o : out30_q;
                        m_data  <= '0;
                        m_valid <= 1'b1;
                        m_last  <= 1'b0;
                        out_idx <= RES_RET;
                        state   <= EMIT;
                    end
                end
                EMIT: begin
                    if (m_hs) begin
                        if (out_idx == RES_O30) begin
                            state   <= LOAD;
                            m_valid <= 1'b0;
                            m_last  <= 1'b0;
                            s_ready <= 1'b1;
                            busy    <= 1'b0;
                            out_idx <= 2'd0;
                        end else begin
                            out_idx <= nidx;
                            m_data  <= nword;
                            m_last  <= (nidx == RES_O30);
                        end
                    end
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

endmodule
